// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: steps T0..T7 per instruction, decodes IR[31:27],
// and drives registered datapath strobes. Tracks run, halt and stop state.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        CONin,
  output logic        INPORTout,
  output logic        OUTPORTin,
  output logic        OUTPORTout,
  output logic        Yout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        write,
  output logic        AluAdd,
  output logic        Run,
  output logic [4:0]  Step
);

  typedef enum logic [4:0] {
    StRst     = 5'd0,
    StT0      = 5'd1,
    StT1      = 5'd2,
    StT2      = 5'd3,
    StAluT3   = 5'd4,
    StAluT4   = 5'd5,
    StImmT4   = 5'd6,
    StAluT5   = 5'd7,
    StLdiT3   = 5'd8,
    StLdiT4   = 5'd9,
    StLdT5    = 5'd10,
    StLdT6    = 5'd11,
    StLdT7    = 5'd12,
    StStT6    = 5'd13,
    StStT7    = 5'd14,
    StBrT3    = 5'd15,
    StBrT4    = 5'd16,
    StBrT5    = 5'd17,
    StBrT6    = 5'd18,
    StJrT3    = 5'd19,
    StInT3    = 5'd20,
    StOutT3   = 5'd21,
    StMfhiT3  = 5'd22,
    StMfloT3  = 5'd23,
    StHalt    = 5'd24,
    StStopped = 5'd25
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11011;

  localparam int unsigned CPcIn      = 0;
  localparam int unsigned CPcOut     = 1;
  localparam int unsigned CIncPc     = 2;
  localparam int unsigned CMarIn     = 3;
  localparam int unsigned CMdrIn     = 4;
  localparam int unsigned CMdrOut    = 5;
  localparam int unsigned CIrIn      = 6;
  localparam int unsigned CYIn       = 7;
  localparam int unsigned CZIn       = 8;
  localparam int unsigned CZloOut    = 9;
  localparam int unsigned CHiOut     = 10;
  localparam int unsigned CLoOut     = 11;
  localparam int unsigned CCOut      = 12;
  localparam int unsigned CConIn     = 13;
  localparam int unsigned CInportOut = 14;
  localparam int unsigned COutportIn = 15;
  localparam int unsigned CGra       = 16;
  localparam int unsigned CGrb       = 17;
  localparam int unsigned CGrc       = 18;
  localparam int unsigned CRin       = 19;
  localparam int unsigned CRout      = 20;
  localparam int unsigned CBaOut     = 21;
  localparam int unsigned CRead      = 22;
  localparam int unsigned CWrite     = 23;
  localparam int unsigned CAluAdd    = 24;
  localparam int unsigned CRun       = 25;
  localparam int unsigned NumCtrl    = 26;

  state_e               state_q, state_d;
  logic [NumCtrl-1:0]   ctrl_q, ctrl_d;
  logic [4:0]           opcode;
  state_e               done_state;
  logic                 unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Strobes for the state being entered; registering them keeps outputs glitch-free.
  function automatic logic [NumCtrl-1:0] decode(input state_e s);
    logic [NumCtrl-1:0] c;
    c = '0;
    c[CRun] = !(s inside {StRst, StHalt, StStopped});
    case (s)
      StT0:     begin c[CPcOut] = 1'b1; c[CMarIn] = 1'b1; end
      StT1:     begin c[CRead] = 1'b1; c[CMdrIn] = 1'b1; c[CPcIn] = 1'b1; c[CIncPc] = 1'b1; end
      StT2:     begin c[CMdrOut] = 1'b1; c[CIrIn] = 1'b1; end
      StAluT3:  begin c[CGrb] = 1'b1; c[CRout] = 1'b1; c[CYIn] = 1'b1; end
      StAluT4:  begin c[CGrc] = 1'b1; c[CRout] = 1'b1; c[CZIn] = 1'b1; end
      StImmT4:  begin c[CCOut] = 1'b1; c[CZIn] = 1'b1; end
      StAluT5:  begin c[CZloOut] = 1'b1; c[CGra] = 1'b1; c[CRin] = 1'b1; end
      StLdiT3:  begin c[CGrb] = 1'b1; c[CBaOut] = 1'b1; c[CYIn] = 1'b1; end
      StLdiT4:  begin c[CCOut] = 1'b1; c[CAluAdd] = 1'b1; c[CZIn] = 1'b1; end
      StLdT5:   begin c[CZloOut] = 1'b1; c[CMarIn] = 1'b1; end
      StLdT6:   begin c[CRead] = 1'b1; c[CMdrIn] = 1'b1; end
      StLdT7:   begin c[CMdrOut] = 1'b1; c[CGra] = 1'b1; c[CRin] = 1'b1; end
      StStT6:   begin c[CGra] = 1'b1; c[CRout] = 1'b1; c[CMdrIn] = 1'b1; end
      StStT7:   c[CWrite] = 1'b1;
      StBrT3:   begin c[CGra] = 1'b1; c[CRout] = 1'b1; c[CConIn] = 1'b1; end
      StBrT4:   begin c[CPcOut] = 1'b1; c[CYIn] = 1'b1; end
      StBrT5:   begin c[CCOut] = 1'b1; c[CAluAdd] = 1'b1; c[CZIn] = 1'b1; end
      StBrT6:   c[CZloOut] = 1'b1;
      StJrT3:   begin c[CGra] = 1'b1; c[CRout] = 1'b1; c[CPcIn] = 1'b1; end
      StInT3:   begin c[CInportOut] = 1'b1; c[CGra] = 1'b1; c[CRin] = 1'b1; end
      StOutT3:  begin c[CGra] = 1'b1; c[CRout] = 1'b1; c[COutportIn] = 1'b1; end
      StMfhiT3: begin c[CHiOut] = 1'b1; c[CGra] = 1'b1; c[CRin] = 1'b1; end
      StMfloT3: begin c[CLoOut] = 1'b1; c[CGra] = 1'b1; c[CRin] = 1'b1; end
      default:  c[CPcIn] = 1'b0;
    endcase
    return c;
  endfunction

  always_comb begin
    done_state = Stop ? StStopped : StT0;
    state_d    = state_q;
    case (state_q)
      StRst:   state_d = done_state;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2: begin
        if (opcode inside {[5'd3:5'd14]}) begin
          state_d = StAluT3;
        end else begin
          case (opcode)
            OpLd, OpLdi, OpSt: state_d = StLdiT3;
            OpBr:              state_d = StBrT3;
            OpJr:              state_d = StJrT3;
            OpIn:              state_d = StInT3;
            OpOut:             state_d = StOutT3;
            OpMfhi:            state_d = StMfhiT3;
            OpMflo:            state_d = StMfloT3;
            OpHalt:            state_d = StHalt;
            default:           state_d = done_state;
          endcase
        end
      end
      StAluT3: state_d = (opcode inside {[5'd12:5'd14]}) ? StImmT4 : StAluT4;
      StAluT4, StImmT4: state_d = StAluT5;
      StLdiT3: state_d = StLdiT4;
      StLdiT4: state_d = (opcode == OpLdi) ? StAluT5 : StLdT5;
      StLdT5:  state_d = (opcode == OpSt) ? StStT6 : StLdT6;
      StLdT6:  state_d = StLdT7;
      StStT6:  state_d = StStT7;
      StBrT3:  state_d = StBrT4;
      StBrT4:  state_d = StBrT5;
      StBrT5:  state_d = StBrT6;
      StAluT5, StLdT7, StStT7, StBrT6, StJrT3, StInT3, StOutT3, StMfhiT3, StMfloT3:
        state_d = done_state;
      StHalt:    state_d = StHalt;
      StStopped: state_d = Stop ? StStopped : StT0;
      default:   state_d = StRst;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StRst;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Branch target loads PC only when the condition flag is set in the final branch step.
  assign PCin       = ctrl_q[CPcIn] | ((state_q == StBrT6) & CON);
  assign PCout      = ctrl_q[CPcOut];
  assign IncPC      = ctrl_q[CIncPc];
  assign MARin      = ctrl_q[CMarIn];
  assign MDRin      = ctrl_q[CMdrIn];
  assign MDRout     = ctrl_q[CMdrOut];
  assign IRin       = ctrl_q[CIrIn];
  assign Yin        = ctrl_q[CYIn];
  assign Zin        = ctrl_q[CZIn];
  assign ZLOout     = ctrl_q[CZloOut];
  assign HIout      = ctrl_q[CHiOut];
  assign LOout      = ctrl_q[CLoOut];
  assign Cout       = ctrl_q[CCOut];
  assign CONin      = ctrl_q[CConIn];
  assign INPORTout  = ctrl_q[CInportOut];
  assign OUTPORTin  = ctrl_q[COutportIn];
  assign Gra        = ctrl_q[CGra];
  assign Grb        = ctrl_q[CGrb];
  assign Grc        = ctrl_q[CGrc];
  assign Rin        = ctrl_q[CRin];
  assign Rout       = ctrl_q[CRout];
  assign BAout      = ctrl_q[CBaOut];
  assign Read       = ctrl_q[CRead];
  assign write      = ctrl_q[CWrite];
  assign AluAdd     = ctrl_q[CAluAdd];
  assign Run        = ctrl_q[CRun];
  assign Step       = state_q;

  // No multiply/divide support, so these datapath strobes never fire.
  assign ZHIout     = 1'b0;
  assign HIin       = 1'b0;
  assign LOin       = 1'b0;
  assign OUTPORTout = 1'b0;
  assign Yout       = 1'b0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected per-cycle step and strobe patterns are queued
// as each instruction is issued and compared cycle by cycle on the falling edge.
module tb_control_unit;

  logic        Clock, Reset, Stop, CON;
  logic [31:0] IR;
  logic PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout, ZHIout, HIin, LOin;
  logic HIout, LOout, Cout, CONin, INPORTout, OUTPORTin, OUTPORTout, Yout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, AluAdd, Run;
  logic [4:0] Step;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .IR(IR), .CON(CON),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout), .CONin(CONin),
    .INPORTout(INPORTout), .OUTPORTin(OUTPORTin), .OUTPORTout(OUTPORTout), .Yout(Yout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read),
    .write(write), .AluAdd(AluAdd), .Run(Run), .Step(Step)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [4:0] SRst = 5'd0,  ST0 = 5'd1,  ST1 = 5'd2,  ST2 = 5'd3;
  localparam logic [4:0] SAluT3 = 5'd4, SAluT4 = 5'd5, SImmT4 = 5'd6, SAluT5 = 5'd7;
  localparam logic [4:0] SLdiT3 = 5'd8, SLdiT4 = 5'd9, SLdT5 = 5'd10, SLdT6 = 5'd11;
  localparam logic [4:0] SLdT7 = 5'd12, SStT6 = 5'd13, SStT7 = 5'd14;
  localparam logic [4:0] SBrT3 = 5'd15, SBrT4 = 5'd16, SBrT5 = 5'd17, SBrT6 = 5'd18;
  localparam logic [4:0] SJrT3 = 5'd19, SInT3 = 5'd20, SOutT3 = 5'd21;
  localparam logic [4:0] SMfhiT3 = 5'd22, SMfloT3 = 5'd23, SHalt = 5'd24, SStopped = 5'd25;

  localparam logic [30:0] PcInM = 31'h1 << 0,  PcOutM = 31'h1 << 1,  IncPcM = 31'h1 << 2;
  localparam logic [30:0] MarInM = 31'h1 << 3, MdrInM = 31'h1 << 4, MdrOutM = 31'h1 << 5;
  localparam logic [30:0] IrInM = 31'h1 << 6,  YinM = 31'h1 << 7,   ZinM = 31'h1 << 8;
  localparam logic [30:0] ZloOutM = 31'h1 << 9, ZhiOutM = 31'h1 << 10, HiInM = 31'h1 << 11;
  localparam logic [30:0] LoInM = 31'h1 << 12, HiOutM = 31'h1 << 13, LoOutM = 31'h1 << 14;
  localparam logic [30:0] CoutM = 31'h1 << 15, ConInM = 31'h1 << 16, InpOutM = 31'h1 << 17;
  localparam logic [30:0] OutpInM = 31'h1 << 18, OutpOutM = 31'h1 << 19, YoutM = 31'h1 << 20;
  localparam logic [30:0] GraM = 31'h1 << 21, GrbM = 31'h1 << 22, GrcM = 31'h1 << 23;
  localparam logic [30:0] RinM = 31'h1 << 24, RoutM = 31'h1 << 25, BaOutM = 31'h1 << 26;
  localparam logic [30:0] ReadM = 31'h1 << 27, WriteM = 31'h1 << 28, AluAddM = 31'h1 << 29;
  localparam logic [30:0] RunM = 31'h1 << 30;
  localparam logic [30:0] DrvM = PcOutM | MdrOutM | ZloOutM | ZhiOutM | HiOutM | LoOutM |
                                 CoutM | InpOutM | OutpOutM | YoutM | RoutM | BaOutM;

  typedef struct {
    string       tag;
    logic [4:0]  step;
    logic [30:0] sig;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [30:0] sample();
    return {Run, AluAdd, write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Yout, OUTPORTout,
            OUTPORTin, INPORTout, CONin, Cout, LOout, HIout, LOin, HIin, ZHIout, ZLOout,
            Zin, Yin, IRin, MDRout, MDRin, MARin, IncPC, PCout, PCin};
  endfunction

  task automatic push(input string tag, input logic [4:0] step, input logic [30:0] sig);
    exp_t e;
    e.tag  = tag;
    e.step = step;
    e.sig  = sig;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch(input string tag);
    push({tag, "_T0"}, ST0, RunM | PcOutM | MarInM);
    push({tag, "_T1"}, ST1, RunM | ReadM | MdrInM | PcInM | IncPcM);
    push({tag, "_T2"}, ST2, RunM | MdrOutM | IrInM);
  endtask

  task automatic drain_one();
    exp_t        e;
    logic [30:0] obs;
    e   = sb_q.pop_front();
    obs = sample();
    checks++;
    assert (Step === e.step) else begin
      failures++;
      $error("FAIL %s step observed=%0d expected=%0d", e.tag, Step, e.step);
    end
    checks++;
    assert (obs === e.sig) else begin
      failures++;
      $error("FAIL %s strobes observed=%h expected=%h", e.tag, obs, e.sig);
    end
    checks++;
    assert ($countones(obs & DrvM) <= 1) else begin
      failures++;
      $error("FAIL %s bus_drivers observed=%h expected=at_most_one", e.tag, obs & DrvM);
    end
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      drain_one();
      @(negedge Clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0;
    Stop  = 1'b0;
    CON   = 1'b0;
    IR    = 32'h0;
    @(negedge Clock);
    repeat (3) push("reset", SRst, '0);
    drain();
    Reset = 1'b1;
    @(negedge Clock);

    IR = 32'h69180019;  // andi R2,R3,$25
    push_fetch("andi");
    push("andi_T3", SAluT3, RunM | GrbM | RoutM | YinM);
    push("andi_T4", SImmT4, RunM | CoutM | ZinM);
    push("andi_T5", SAluT5, RunM | ZloOutM | GraM | RinM);
    drain();

    IR = 32'h18000000;  // add
    push_fetch("add");
    push("add_T3", SAluT3, RunM | GrbM | RoutM | YinM);
    push("add_T4", SAluT4, RunM | GrcM | RoutM | ZinM);
    push("add_T5", SAluT5, RunM | ZloOutM | GraM | RinM);
    drain();

    IR  = 32'h98000000;  // br, taken
    CON = 1'b1;
    push_fetch("br1");
    push("br1_T3", SBrT3, RunM | GraM | RoutM | ConInM);
    push("br1_T4", SBrT4, RunM | PcOutM | YinM);
    push("br1_T5", SBrT5, RunM | CoutM | AluAddM | ZinM);
    push("br1_T6", SBrT6, RunM | ZloOutM | PcInM);
    drain();

    CON = 1'b0;  // br, not taken
    push_fetch("br0");
    push("br0_T3", SBrT3, RunM | GraM | RoutM | ConInM);
    push("br0_T4", SBrT4, RunM | PcOutM | YinM);
    push("br0_T5", SBrT5, RunM | CoutM | AluAddM | ZinM);
    push("br0_T6", SBrT6, RunM | ZloOutM);
    drain();

    IR = 32'h10000000;  // st
    push_fetch("st");
    push("st_T3", SLdiT3, RunM | GrbM | BaOutM | YinM);
    push("st_T4", SLdiT4, RunM | CoutM | AluAddM | ZinM);
    push("st_T5", SLdT5, RunM | ZloOutM | MarInM);
    push("st_T6", SStT6, RunM | GraM | RoutM | MdrInM);
    push("st_T7", SStT7, RunM | WriteM);
    drain();

    IR = 32'h08000000;  // ldi
    push_fetch("ldi");
    push("ldi_T3", SLdiT3, RunM | GrbM | BaOutM | YinM);
    push("ldi_T4", SLdiT4, RunM | CoutM | AluAddM | ZinM);
    push("ldi_T5", SAluT5, RunM | ZloOutM | GraM | RinM);
    drain();

    IR = 32'h00000000;  // ld
    push_fetch("ld");
    push("ld_T3", SLdiT3, RunM | GrbM | BaOutM | YinM);
    push("ld_T4", SLdiT4, RunM | CoutM | AluAddM | ZinM);
    push("ld_T5", SLdT5, RunM | ZloOutM | MarInM);
    push("ld_T6", SLdT6, RunM | ReadM | MdrInM);
    push("ld_T7", SLdT7, RunM | MdrOutM | GraM | RinM);
    drain();

    IR = 32'hA0000000;
    push_fetch("jr");
    push("jr_T3", SJrT3, RunM | GraM | RoutM | PcInM);
    drain();
    IR = 32'hB0000000;
    push_fetch("in");
    push("in_T3", SInT3, RunM | InpOutM | GraM | RinM);
    drain();
    IR = 32'hB8000000;
    push_fetch("out");
    push("out_T3", SOutT3, RunM | GraM | RoutM | OutpInM);
    drain();
    IR = 32'hC0000000;
    push_fetch("mfhi");
    push("mfhi_T3", SMfhiT3, RunM | HiOutM | GraM | RinM);
    drain();
    IR = 32'hC8000000;
    push_fetch("mflo");
    push("mflo_T3", SMfloT3, RunM | LoOutM | GraM | RinM);
    drain();
    IR = 32'hD0000000;
    push_fetch("nop");
    drain();
    IR = 32'hF8000000;  // unsupported opcode behaves as nop
    push_fetch("unsup");
    drain();

    IR   = 32'h18000000;  // add with Stop held throughout
    Stop = 1'b1;
    push_fetch("stop_add");
    push("stop_add_T3", SAluT3, RunM | GrbM | RoutM | YinM);
    push("stop_add_T4", SAluT4, RunM | GrcM | RoutM | ZinM);
    push("stop_add_T5", SAluT5, RunM | ZloOutM | GraM | RinM);
    repeat (2) push("stopped", SStopped, '0);
    drain();
    Stop = 1'b0;
    push("stopped_release", SStopped, '0);
    drain();

    IR = 32'hD8000000;  // halt
    push_fetch("halt");
    repeat (20) push("halted", SHalt, '0);
    drain();
    Reset = 1'b0;
    #1;
    push("halt_reset", SRst, '0);
    drain();
    Reset = 1'b1;
    @(negedge Clock);

    IR = 32'h00000000;  // ld aborted by reset in its memory read step
    push_fetch("ldabort");
    push("ldabort_T3", SLdiT3, RunM | GrbM | BaOutM | YinM);
    push("ldabort_T4", SLdiT4, RunM | CoutM | AluAddM | ZinM);
    push("ldabort_T5", SLdT5, RunM | ZloOutM | MarInM);
    drain();
    push("ldabort_T6", SLdT6, RunM | ReadM | MdrInM);
    drain_one();
    #1;
    Reset = 1'b0;
    #1;
    push("ldabort_rst", SRst, '0);
    drain_one();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    IR = 32'hD0000000;
    push_fetch("post_nop");
    push("post_nop_next", ST0, RunM | PcOutM | MarInM);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
